// File: rtl/demux_buf.sv
// 1:NUM_OUT demultiplexer with a one-entry holding register and valid/ready handshake per channel.
// Also keeps a sticky out-of-range select flag and a wrapping count of accepted words.
module demux_buf #(
    parameter int W         = 16,
    parameter int NUM_OUT   = 4,
    parameter int SEL_W     = 2,
    parameter int HOLD_LAST = 1,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         data_in,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 en,
    output logic                 in_ready,
    output logic [NUM_OUT*W-1:0] data_out,
    output logic [NUM_OUT-1:0]   out_valid,
    input  logic [NUM_OUT-1:0]   out_ready,
    output logic                 sel_err,
    output logic [CNT_W-1:0]     xfer_cnt
);

    logic [W-1:0]       data_r [NUM_OUT];
    logic [NUM_OUT-1:0] out_valid_r;
    logic               sel_err_r;
    logic [CNT_W-1:0]   xfer_cnt_r;

    logic [NUM_OUT-1:0] sel_hit_s;
    logic [NUM_OUT-1:0] load_s;
    logic [NUM_OUT-1:0] drain_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               sel_bad_s;

    // Select decode and handshake; an out-of-range select yields an all-zero hit vector.
    always_comb begin
        sel_hit_s = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if ({1'b0, sel} == (SEL_W+1)'(k)) begin
                sel_hit_s[k] = 1'b1;
            end else begin
                sel_hit_s[k] = 1'b0;
            end
        end
        in_ready_s = |(sel_hit_s & (~out_valid_r | out_ready));
        accept_s   = en && in_ready_s;
        sel_bad_s  = en && (sel_hit_s == '0);
        if (accept_s) begin
            load_s = sel_hit_s;
        end else begin
            load_s = '0;
        end
        drain_s = out_valid_r & out_ready & ~load_s;
    end

    // Channel holding registers: a reload wins over a drain of the same channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                data_r[k] <= '0;
            end
            out_valid_r <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (load_s[k]) begin
                    data_r[k]      <= data_in;
                    out_valid_r[k] <= 1'b1;
                end else if (drain_s[k]) begin
                    out_valid_r[k] <= 1'b0;
                    if (HOLD_LAST == 0) begin
                        data_r[k] <= '0;
                    end else begin
                        data_r[k] <= data_r[k];
                    end
                end else begin
                    data_r[k]      <= data_r[k];
                    out_valid_r[k] <= out_valid_r[k];
                end
            end
        end
    end

    // Accepted-word counter and sticky select error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt_r <= '0;
            sel_err_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                xfer_cnt_r <= xfer_cnt_r + CNT_W'(1);
            end else begin
                xfer_cnt_r <= xfer_cnt_r;
            end
            if (sel_bad_s) begin
                sel_err_r <= 1'b1;
            end else begin
                sel_err_r <= sel_err_r;
            end
        end
    end

    // Pack channel registers onto the flat output bus.
    always_comb begin
        data_out = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            data_out[k*W +: W] = data_r[k];
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign sel_err   = sel_err_r;
    assign xfer_cnt  = xfer_cnt_r;

endmodule
